usb_tx_sequencer: RTL and testbench
===================================

# usb_tx_sequencer

Full-speed USB transmit sequencer that owns the bit-stuffing datapath on the TX side of the bridge. It accepts packet bytes from the TX packet buffer over a valid/ready handshake and emits SYNC, the serialized payload and EOP. Payload is sent LSB-first with a zero stuffed after every six consecutive ones, NRZI-encoded onto the D+/D- pins. It paces everything from a bit-period timer derived from the system clock.

## Interface
Parameters:
- CLKS_PER_BIT, 8, system clocks per USB bit time (≥2)

Ports:
- clk  input  1  system clock, all logic rising-edge
- n_rst  input  1  reset, asynchronous, active-low
- tx_start  input  1  pulse; begin a packet (sampled only in IDLE)
- tx_data  input  8  next payload byte
- tx_data_valid  input  1  tx_data/tx_last valid
- tx_last  input  1  qualifies tx_data as final byte of packet
- tx_data_ready  output  1  one-cycle pop strobe; byte captured this edge
- d_plus  output  1  D+ line level
- d_minus  output  1  D- line level
- tx_busy  output  1  high from accepted tx_start until EOP complete
- tx_done  output  1  one-cycle pulse at end of EOP J bit
- tx_error  output  1  one-cycle pulse on buffer underrun

## Operation
- States: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
- Line encoding: J = (d_plus=1, d_minus=0), K = (0,1), SE0 = (0,0). IDLE drives J.
- NRZI: raw 0 toggles J/K, raw 1 holds level. Encoder state is reset to J at each packet start.
- Bit timer counts 0..CLKS_PER_BIT-1. The bit strobe fires at CLKS_PER_BIT-1. Every state change except IDLE exit occurs on a strobe.
- IDLE→SYNC on tx_start. SYNC sends raw 00000001, i.e. line KJKJKJKK.
- Ones counter (3-bit) tracks consecutive raw ones. It starts at 0 at SYNC and counts SYNC's final 1.
  - It clears on any raw 0, including a stuffed 0.
  - When it reaches 6 after a transmitted bit, the next bit period is STUFF: a raw 0 that does not advance the bit index. The counter then returns to 0.
- Byte load: on the strobe ending SYNC bit 7 or DATA bit 7 (non-last byte), assert tx_data_ready for that cycle if tx_data_valid=1. Load tx_data into the shift register and tx_last into a flag.
  - If a stuff bit is due at that boundary, STUFF is sent first and the load is deferred to STUFF's strobe.
- Underrun: tx_data_valid=0 at a required load. Pulse tx_error, skip further data and go to EOP_SE0.
- After bit 7 of the last byte, plus any pending stuff bit: EOP_SE0 for 2 bit times, then EOP_J for 1 bit time.
- At the end of EOP_J: tx_done pulses, tx_busy falls, and the block returns to IDLE.
- tx_start while busy: ignored.

## Timing
- Reset values: d_plus=1, d_minus=0, tx_busy=0, tx_done=0, tx_data_ready=0, tx_error=0, state IDLE, timer 0, ones counter 0.
- Asserting n_rst mid-packet forces these values immediately, without waiting for clk.
- Outputs are registered. On the edge sampling tx_start in IDLE, the lines go to K (first SYNC bit) and tx_busy=1. Timer restarts at 0.
- Each line symbol is held exactly CLKS_PER_BIT cycles, with no gaps between bits.
- tx_data_ready is high for exactly one cycle per byte, coincident with the strobe. tx_data and tx_last must be stable in that cycle.
- Packet length in cycles = CLKS_PER_BIT × (8 + 8·N + stuffed bits + 3), measured from the tx_start edge to the tx_done edge inclusive.

## Test plan
- Reset idle: hold n_rst=0, then release. Required: d_plus=1, d_minus=0, all strobes 0 for 100 cycles.
- SYNC plus 0x00 last (CLKS_PER_BIT=8), sampling d_plus once per bit:
  - Bits 0..7 (SYNC): 0,1,0,1,0,1,0,0.
  - Bits 8..15 (data): 1,0,1,0,1,0,1,0, with no stuffing.
  - Bits 16..18 (EOP): SE0, SE0, J.
  - tx_done on cycle 152; exactly 1 tx_data_ready.
- 0xFF last:
  - Stuff bit inserted after data bit 4 (SYNC 1 + five ones); the line toggles K→J there.
  - Total 17 bits before EOP; tx_done on cycle 160.
- Two-byte packet 0xA5, 0x3C (last):
  - tx_data_ready pulses on cycles 63 and 127.
  - Decoded NRZI/destuffed stream equals 0xA5, 0x3C LSB-first.
- Underrun: 2-byte packet with tx_data_valid=0 at the second load. Required:
  - tx_error pulses once.
  - EOP follows immediately (SE0, SE0, J).
  - tx_done pulses and the block returns to IDLE.
- Mid-packet reset and start-while-busy:
  - Assert n_rst during data → lines J at once, tx_busy=0.
  - tx_start during a packet → no effect on the bit stream.

Source files
------------

// File: rtl/usb_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_sequencer_if
// Description : Packet-byte handshake and USB line bundle for usb_tx_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_tx_sequencer_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_last;
    logic       tx_data_ready;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_start, tx_data, tx_data_valid, tx_last,
        input  tx_data_ready, d_plus, d_minus, tx_busy, tx_done, tx_error
    );

    modport slave (
        input  tx_start, tx_data, tx_data_valid, tx_last,
        output tx_data_ready, d_plus, d_minus, tx_busy, tx_done, tx_error
    );
endinterface
`default_nettype wire

// File: rtl/usb_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_sequencer
// Description : Full-speed USB TX: SYNC, LSB-first bit-stuffed payload, EOP,
//               NRZI-encoded onto D+/D-, paced by a bit-period timer.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_sequencer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    usb_tx_sequencer_if.slave  bus
);

    localparam int unsigned       c_TW   = $clog2(CLKS_PER_BIT);
    localparam logic [c_TW-1:0]   c_LAST = c_TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_DATA    = 3'd2,
        S_STUFF   = 3'd3,
        S_EOP_SE0 = 3'd4,
        S_EOP_J   = 3'd5
    } state_t;

    state_t          state_q,  state_d;
    logic [c_TW-1:0] timer_q,  timer_d;
    logic [2:0]      idx_q,    idx_d;
    logic [2:0]      ones_q,   ones_d;
    logic [7:0]      shift_q,  shift_d;
    logic            last_q,   last_d;
    logic            level_q,  level_d;
    logic            dp_q,     dp_d;
    logic            dm_q,     dm_d;
    logic            busy_q,   busy_d;
    logic            done_q,   done_d;
    logic            err_q,    err_d;

    logic            w_strobe;
    logic            w_raw;
    logic [2:0]      w_ones_inc;
    logic            w_new_bit;
    logic            w_boundary;
    logic            w_ready;
    logic            w_base;
    logic            w_raw_nxt;

    // Raw (pre-NRZI) value of the bit currently on the line
    always_comb begin
        w_raw = 1'b0;
        case (state_q)
            S_SYNC:  w_raw = (idx_q == 3'd7);
            S_DATA:  w_raw = shift_q[0];
            default: w_raw = 1'b0;
        endcase
    end

    assign w_strobe   = (state_q != S_IDLE) && (timer_q == c_LAST);
    assign w_ones_inc = w_raw ? (ones_q + 3'd1) : 3'd0;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        ones_d     = ones_q;
        shift_d    = shift_q;
        last_d     = last_q;
        level_d    = level_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        w_ready    = 1'b0;
        w_new_bit  = 1'b0;
        w_boundary = 1'b0;
        w_raw_nxt  = 1'b0;
        w_base     = (state_q == S_IDLE) ? 1'b1 : level_q;

        if (state_q != S_IDLE) begin
            timer_d = w_strobe ? '0 : timer_q + c_TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.tx_start) begin
                    state_d   = S_SYNC;
                    timer_d   = '0;
                    idx_d     = 3'd0;
                    ones_d    = 3'd0;
                    last_d    = 1'b0;
                    w_new_bit = 1'b1;
                end
            end
            S_SYNC, S_DATA: begin
                if (w_strobe) begin
                    ones_d    = w_ones_inc;
                    w_new_bit = 1'b1;
                    if (w_ones_inc == 3'd6) begin
                        state_d = S_STUFF;
                    end else if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                        if (state_q == S_DATA) shift_d = shift_q >> 1;
                    end else begin
                        w_boundary = 1'b1;
                    end
                end
            end
            S_STUFF: begin
                // Stuffed zero occupies a bit period without advancing the payload
                if (w_strobe) begin
                    ones_d    = 3'd0;
                    w_new_bit = 1'b1;
                    if (idx_q != 3'd7) begin
                        state_d = S_DATA;
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end else begin
                        w_boundary = 1'b1;
                    end
                end
            end
            S_EOP_SE0: begin
                if (w_strobe) begin
                    if (idx_q == 3'd0) idx_d   = 3'd1;
                    else               state_d = S_EOP_J;
                end
            end
            S_EOP_J: begin
                if (w_strobe) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Byte boundary: finish the packet, load the next byte, or flag underrun
        if (w_boundary) begin
            idx_d = 3'd0;
            if ((state_q != S_SYNC) && last_q) begin
                state_d = S_EOP_SE0;
            end else if (bus.tx_data_valid) begin
                w_ready = 1'b1;
                shift_d = bus.tx_data;
                last_d  = bus.tx_last;
                state_d = S_DATA;
            end else begin
                err_d   = 1'b1;
                state_d = S_EOP_SE0;
            end
        end

        case (state_d)
            S_SYNC:  w_raw_nxt = (idx_d == 3'd7);
            S_DATA:  w_raw_nxt = shift_d[0];
            default: w_raw_nxt = 1'b0;
        endcase

        if (w_new_bit && ((state_d == S_SYNC) || (state_d == S_DATA) || (state_d == S_STUFF))) begin
            level_d = w_raw_nxt ? w_base : ~w_base;
        end
    end

    always_comb begin
        dp_d   = 1'b1;
        dm_d   = 1'b0;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_EOP_SE0: begin
                dp_d = 1'b0;
                dm_d = 1'b0;
            end
            S_SYNC, S_DATA, S_STUFF: begin
                dp_d = level_d;
                dm_d = ~level_d;
            end
            default: begin
                dp_d = 1'b1;
                dm_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= 3'd0;
            ones_q  <= 3'd0;
            shift_q <= 8'd0;
            last_q  <= 1'b0;
            level_q <= 1'b1;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            level_q <= level_d;
            dp_q    <= dp_d;
            dm_q    <= dm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Pop strobe is qualified by the strobe cycle so the byte is taken on this edge
    assign bus.tx_data_ready = w_ready;
    assign bus.d_plus        = dp_q;
    assign bus.d_minus       = dm_q;
    assign bus.tx_busy       = busy_q;
    assign bus.tx_done       = done_q;
    assign bus.tx_error      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx_sequencer
// Description : Self-checking bench for usb_tx_sequencer against a bit-stream model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_sequencer;

    localparam int CPB = 8;

    logic clk;
    logic n_rst;

    usb_tx_sequencer_if bus();

    usb_tx_sequencer #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Packet under test and model results
    logic [7:0] pkt_data[$];
    bit         pkt_avail[$];
    logic [1:0] exp_sym[$];
    int         exp_rdy[$];
    int         exp_err;
    int         exp_done;
    int         exp_nbytes;

    // Observations
    int         obs_rdy[$];
    logic [1:0] obs_sym[$];
    int         obs_done;
    int         obs_err;
    int         n_done;
    int         n_err;

    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    // Reference: build the raw bit list, stuff, NRZI-encode, append EOP
    task automatic model();
        bit raw[$];
        int ones;
        bit lvl;
        raw.delete();
        exp_sym.delete();
        exp_rdy.delete();
        exp_err    = -1;
        exp_nbytes = 0;
        for (int i = 0; i < 7; i++) raw.push_back(1'b0);
        raw.push_back(1'b1);
        ones = 1;
        for (int k = 0; k < pkt_data.size(); k++) begin
            if (!pkt_avail[k]) begin
                exp_err = CPB * raw.size();
                break;
            end
            exp_rdy.push_back(CPB * raw.size() - 1);
            exp_nbytes++;
            for (int b = 0; b < 8; b++) begin
                bit v;
                v = pkt_data[k][b];
                raw.push_back(v);
                ones = v ? ones + 1 : 0;
                if (ones == 6) begin
                    raw.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        lvl = 1'b1;
        foreach (raw[i]) begin
            if (!raw[i]) lvl = ~lvl;
            exp_sym.push_back({lvl, ~lvl});
        end
        exp_sym.push_back(SYM_SE0);
        exp_sym.push_back(SYM_SE0);
        exp_sym.push_back(SYM_J);
        exp_done = CPB * exp_sym.size();
    endtask

    task automatic present(input int k);
        if (k < pkt_data.size()) begin
            bus.tx_data       = pkt_data[k];
            bus.tx_last       = (k == pkt_data.size() - 1);
            bus.tx_data_valid = pkt_avail[k];
        end else begin
            bus.tx_data       = 8'h00;
            bus.tx_last       = 1'b0;
            bus.tx_data_valid = 1'b0;
        end
    endtask

    // NRZI-decode and destuff the mid-bit samples, then compare payload bytes
    task automatic decode_check(input string name);
        logic [1:0] prev;
        int         ones;
        int         nsync;
        int         nb;
        logic [7:0] acc;
        logic [7:0] got[$];
        bit         r;
        prev  = SYM_J;
        ones  = 0;
        nsync = 0;
        nb    = 0;
        acc   = 8'h00;
        got.delete();
        foreach (obs_sym[i]) begin
            if (obs_sym[i] == SYM_SE0) break;
            r    = (obs_sym[i] == prev);
            prev = obs_sym[i];
            if (nsync < 8) begin
                nsync++;
                ones = r ? ones + 1 : 0;
            end else if (ones == 6) begin
                ones = 0;
            end else begin
                ones = r ? ones + 1 : 0;
                acc[nb] = r;
                nb++;
                if (nb == 8) begin
                    got.push_back(acc);
                    nb = 0;
                end
            end
        end
        chk($sformatf("%s decoded byte count", name), got.size(), exp_nbytes);
        for (int i = 0; i < got.size() && i < exp_nbytes; i++)
            chk($sformatf("%s decoded byte %0d", name, i), got[i], pkt_data[i]);
    endtask

    task automatic run_packet(input string name, input int poke);
        int k;
        int limit;
        model();
        k = 0;
        present(k);
        obs_rdy.delete();
        obs_sym.delete();
        obs_done = -1;
        obs_err  = -1;
        n_done   = 0;
        n_err    = 0;
        limit    = exp_done + 3;
        @(negedge clk);
        bus.tx_start = 1'b1;
        @(posedge clk);
        #1 bus.tx_start = 1'b0;
        for (int c = 0; c < limit; c++) begin
            bit popped;
            int b;
            @(negedge clk);
            b = c / CPB;
            if (c < exp_done && ((c % CPB) == 0 || (c % CPB) == CPB - 1))
                chk($sformatf("%s line bit%0d cyc%0d", name, b, c),
                    {bus.d_plus, bus.d_minus}, exp_sym[b]);
            if ((c % CPB) == CPB / 2) obs_sym.push_back({bus.d_plus, bus.d_minus});
            if (c == exp_done - 1) chk($sformatf("%s busy before done", name), bus.tx_busy, 1);
            if (c == exp_done) begin
                chk($sformatf("%s busy after done", name), bus.tx_busy, 0);
                chk($sformatf("%s idle line", name), {bus.d_plus, bus.d_minus}, SYM_J);
            end
            popped = bus.tx_data_ready;
            if (popped) obs_rdy.push_back(c);
            if (bus.tx_done) begin
                if (obs_done < 0) obs_done = c;
                n_done++;
            end
            if (bus.tx_error) begin
                if (obs_err < 0) obs_err = c;
                n_err++;
            end
            @(posedge clk);
            #1;
            if (popped) begin
                k++;
                present(k);
            end
            bus.tx_start = (c + 1 == poke);
        end
        bus.tx_start = 1'b0;
        chk($sformatf("%s done cycle", name), obs_done, exp_done);
        chk($sformatf("%s done pulses", name), n_done, 1);
        chk($sformatf("%s error cycle", name), obs_err, exp_err);
        chk($sformatf("%s error pulses", name), n_err, (exp_err >= 0) ? 1 : 0);
        chk($sformatf("%s ready count", name), obs_rdy.size(), exp_rdy.size());
        for (int i = 0; i < obs_rdy.size() && i < exp_rdy.size(); i++)
            chk($sformatf("%s ready %0d cycle", name, i), obs_rdy[i], exp_rdy[i]);
        decode_check(name);
        repeat (3) @(posedge clk);
    endtask

    task automatic idle_check(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (bus.d_plus !== 1'b1 || bus.d_minus !== 1'b0 || bus.tx_busy !== 1'b0 ||
                bus.tx_done !== 1'b0 || bus.tx_error !== 1'b0 || bus.tx_data_ready !== 1'b0)
                bad++;
        end
        chk($sformatf("%s idle violations", name), bad, 0);
    endtask

    initial begin
        n_rst             = 1'b0;
        bus.tx_start      = 1'b0;
        bus.tx_data       = 8'h00;
        bus.tx_data_valid = 1'b0;
        bus.tx_last       = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("reset d_plus", bus.d_plus, 1);
        chk("reset d_minus", bus.d_minus, 0);
        chk("reset tx_busy", bus.tx_busy, 0);
        @(negedge clk);
        n_rst = 1'b1;
        idle_check("post-reset", 100);

        // SYNC + 0x00 last
        pkt_data = '{8'h00};
        pkt_avail = '{1'b1};
        run_packet("p00", -1);
        chk("p00 tx_done at 152", obs_done, 152);
        chk("p00 one ready", obs_rdy.size(), 1);

        // 0xFF last: one stuff bit mid-byte
        pkt_data = '{8'hFF};
        pkt_avail = '{1'b1};
        run_packet("pFF", -1);
        chk("pFF tx_done at 160", obs_done, 160);

        // Two-byte packet
        pkt_data = '{8'hA5, 8'h3C};
        pkt_avail = '{1'b1, 1'b1};
        run_packet("pA53C", -1);
        chk("pA53C ready0 at 63", (obs_rdy.size() > 0) ? obs_rdy[0] : -1, 63);
        chk("pA53C ready1 at 127", (obs_rdy.size() > 1) ? obs_rdy[1] : -1, 127);

        // Underrun at second load
        pkt_data = '{8'h5A, 8'h81};
        pkt_avail = '{1'b1, 1'b0};
        run_packet("under", -1);
        chk("under error pulses", n_err, 1);

        // Stuff bit landing exactly on a byte boundary
        pkt_data = '{8'hFC, 8'h00};
        pkt_avail = '{1'b1, 1'b1};
        run_packet("bndFC", -1);
        pkt_data = '{8'hFC};
        pkt_avail = '{1'b1};
        run_packet("lastFC", -1);
        pkt_data = '{8'hFC, 8'h11};
        pkt_avail = '{1'b1, 1'b0};
        run_packet("underFC", -1);

        // tx_start while busy must not disturb the stream
        pkt_data = '{8'h96, 8'hF0};
        pkt_avail = '{1'b1, 1'b1};
        run_packet("poke", 90);

        // Mid-packet asynchronous reset
        pkt_data = '{8'h55, 8'hAA, 8'h0F};
        pkt_avail = '{1'b1, 1'b1, 1'b1};
        present(0);
        @(negedge clk);
        bus.tx_start = 1'b1;
        @(posedge clk);
        #1 bus.tx_start = 1'b0;
        repeat (100) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("async reset d_plus", bus.d_plus, 1);
        chk("async reset d_minus", bus.d_minus, 0);
        chk("async reset tx_busy", bus.tx_busy, 0);
        present(99);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        idle_check("after mid reset", 20);

        // Randomized packets
        for (int p = 0; p < 24; p++) begin
            int len;
            int poke;
            pkt_data.delete();
            pkt_avail.delete();
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       pkt_data.push_back(8'hFF);
                    1:       pkt_data.push_back(8'hFC);
                    default: pkt_data.push_back(8'($urandom_range(0, 255)));
                endcase
                pkt_avail.push_back(($urandom_range(0, 9) != 0) || (i == 0));
            end
            model();
            poke = ($urandom_range(0, 1) == 1) ? $urandom_range(10, exp_done - 20) : -1;
            run_packet($sformatf("rnd%0d", p), poke);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
